laa_exec_unit: RTL and testbench
================================

Name: laa_exec_unit

Overview:
Accelerator-side datapath of the LAA, directly downstream of the LAA instruction decoder. It consumes the decoded LAA bus command (opcode, LAA register address, write data) and holds the 32 x 32-bit LAA register file. It services READ and WRITE in a single cycle and runs MULTIPLY as a multi-cycle dot-product sequence, then returns read data and completion status to the decoder.

Parameters:
VEC_LEN, 8, number of elements in the MULTIPLY dot product; legal range 1..16.
DATA_W, 32, width of LAA registers, datain and dataout.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  reset, asynchronous and active-high.
opcode  in  2  command: NONE=0, READ=1, WRITE=2, MULTIPLY=3.
addr  in  5  LAA register address. Source for READ, destination for WRITE and MULTIPLY.
datain  in  DATA_W  write data for WRITE.
cmd_valid  in  1  command strobe from decoder.
cmd_ready  out  1  unit can accept a command (high only in IDLE).
dataout  out  DATA_W  registered READ result.
dataout_valid  out  1  one-cycle pulse; dataout carries a new READ result.
busy  out  1  MULTIPLY in progress (equals !cmd_ready).
done  out  1  one-cycle pulse; MULTIPLY result has been written.

Behaviour:
- Reset (asynchronous, any state):
  - All 32 LAA registers cleared to 0.
  - State forced to IDLE; element counter and accumulator cleared to 0.
  - Outputs: dataout=0, dataout_valid=0, done=0, busy=0, cmd_ready=1.
  - A MULTIPLY in flight is aborted with no write and no done pulse.
- Accept rule: a command is accepted on a rising edge where cmd_valid && cmd_ready && opcode!=NONE.
  - cmd_valid with opcode NONE is ignored and produces no response.
  - cmd_valid while cmd_ready=0 is ignored; the decoder must hold or reissue the command.
- WRITE: reg[addr] <= datain on the accept edge. No output pulse. The new value is readable by a READ accepted on the next edge.
- READ: on the accept edge, dataout <= reg[addr] and dataout_valid <= 1. dataout_valid is high for exactly the following cycle. dataout holds its value until the next READ.
  - Back-to-back READs give a pulse in each cycle.
  - WRITE then READ of the same address on consecutive edges returns the written value.
- MULTIPLY FSM, states IDLE -> MAC -> WB -> IDLE:
  - IDLE: cmd_ready=1. Accepting MULTIPLY latches dst=addr, clears acc and idx, and moves to MAC.
  - MAC: on each edge, acc <= acc + low32(reg[idx] * reg[16+idx]) and idx <= idx+1. After the edge with idx=VEC_LEN-1, move to WB. This takes exactly VEC_LEN edges.
  - WB: on that edge, reg[dst] <= acc and done <= 1, then move to IDLE.
  - Timing: cmd_ready is low for VEC_LEN+1 cycles after the accept edge. done is high in the same cycle cmd_ready returns high.
- Arithmetic:
  - Products are truncated to the low 32 bits; signed and unsigned give the same result.
  - The accumulator wraps modulo 2^32; there is no overflow flag.
- Operand/destination overlap: dst may lie in the operand range (0..VEC_LEN-1 or 16..16+VEC_LEN-1). All operands are read in MAC before WB writes, so the result is unaffected by overlap.
- busy = (state != IDLE). dataout and dataout_valid are unaffected by MULTIPLY.
- Illegal VEC_LEN (outside 1..16) is a fatal elaboration error.

Test Plan:
- Reset/idle: assert rst mid-run, release -> cmd_ready=1, busy=0, done=0, dataout=0; READ of every address returns 0.
- WRITE/READ: WRITE reg5=0xDEADBEEF, then READ reg5 on the next cycle -> dataout=0xDEADBEEF with dataout_valid high for exactly 1 cycle.
- MULTIPLY (VEC_LEN=8):
  - Stimulus: reg[i]=i+1 and reg[16+i]=2 for i=0..7; MULTIPLY addr=31.
  - Expect: cmd_ready low for 9 cycles, done pulse, then READ reg31 = 72 (0x48).
- Wrap and overlap:
  - Stimulus: reg0=reg16=0xFFFFFFFF, rest 0, VEC_LEN=8; MULTIPLY addr=0.
  - Expect: reg0 = 0x00000001.
- Busy blocking and NONE: issue a WRITE reg3=7 while busy -> ignored, reg3 unchanged. cmd_valid with opcode NONE in IDLE -> no pulse and no state change.
- Reset mid-MULTIPLY: assert rst in MAC cycle 4 -> no done pulse, all registers 0, cmd_ready=1 after rst deasserts.

Source files
------------

// File: rtl/laa_exec_unit.sv
// LAA execution unit: 32 x DATA_W register file with single-cycle READ/WRITE
// and a multi-cycle MULTIPLY that writes a VEC_LEN dot product
// of reg[0..] and reg[16..] into a destination register.
module laa_exec_unit #(
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        opcode,
    input  logic [4:0]        addr,
    input  logic [DATA_W-1:0] datain,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              dataout_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NREG  = 32;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned AW    = 5;

    localparam logic [1:0] OP_NONE     = 2'd0;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WRITE    = 2'd2;
    localparam logic [1:0] OP_MULTIPLY = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

    // Reject vector lengths that the 4-bit element index cannot address
    if (VEC_LEN < 1 || VEC_LEN > 16) begin : g_bad_vec_len
        $fatal(1, "laa_exec_unit: VEC_LEN must be in 1..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              dataout_valid_q, dataout_valid_d;
    logic              done_q, done_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              accept_c;

    assign accept_c = cmd_valid && cmd_ready_q && (opcode != OP_NONE);

    // Next-state: command decode in IDLE, MAC accumulation, WB of the result
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        acc_d           = acc_q;
        dst_d           = dst_q;
        regs_d          = regs_q;
        dataout_d       = dataout_q;
        dataout_valid_d = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    case (opcode)
                        OP_READ: begin
                            dataout_d       = regs_q[addr];
                            dataout_valid_d = 1'b1;
                        end
                        OP_WRITE: begin
                            regs_d[addr] = datain;
                        end
                        OP_MULTIPLY: begin
                            dst_d   = addr;
                            acc_d   = '0;
                            idx_d   = '0;
                            state_d = ST_MAC;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MAC: begin
                // Product truncates to DATA_W; accumulator wraps modulo 2^DATA_W
                acc_d = acc_q + (regs_q[{1'b0, idx_q}] * regs_q[{1'b1, idx_q}]);
                idx_d = IDX_W'(idx_q + 1'b1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                // All operands were consumed in MAC, so dst overlap is harmless
                regs_d[dst_q] = acc_q;
                done_d        = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, register file and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            acc_q           <= '0;
            dst_q           <= '0;
            dataout_q       <= '0;
            dataout_valid_q <= 1'b0;
            done_q          <= 1'b0;
            cmd_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            acc_q           <= acc_d;
            dst_q           <= dst_d;
            dataout_q       <= dataout_d;
            dataout_valid_q <= dataout_valid_d;
            done_q          <= done_d;
            cmd_ready_q     <= cmd_ready_d;
            busy_q          <= busy_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign dataout       = dataout_q;
    assign dataout_valid = dataout_valid_q;
    assign done          = done_q;

endmodule

// File: tb/tb_laa_exec_unit.sv
// Testbench for laa_exec_unit: directed and randomized commands checked
// against an array-based register model with a plain-arithmetic dot product.
module tb_laa_exec_unit;

    localparam int unsigned VL = 8;
    localparam int unsigned DW = 32;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_MUL   = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    opcode;
    logic [4:0]    addr;
    logic [DW-1:0] datain;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] dataout;
    logic          dataout_valid;
    logic          busy;
    logic          done;

    int vectors = 0;
    int errs    = 0;

    logic [31:0] model [32];
    logic [31:0] last_read;

    laa_exec_unit #(.VEC_LEN(VL), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .addr          (addr),
        .datain        (datain),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single edge, then return the bus to idle
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        opcode    = op;
        addr      = a;
        datain    = d;
        step();
        cmd_valid = 1'b0;
        opcode    = OP_NONE;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        issue(OP_WRITE, a, d);
        model[a] = d;
    endtask

    task automatic do_read(input string tag, input logic [4:0] a);
        issue(OP_READ, a, 32'h0);
        chk({tag, "_valid"}, 32'(dataout_valid), 32'd1);
        chk({tag, "_data"}, dataout, model[a]);
        last_read = model[a];
    endtask

    function automatic logic [31:0] dot_model();
        logic [31:0] s = 32'h0;
        for (int i = 0; i < int'(VL); i++) begin
            s = s + model[i] * model[16 + i];
        end
        return s;
    endfunction

    // Wait for the unit to return to idle and check latency and the done pulse
    task automatic finish_mult(input string tag, input int pre);
        int low = pre;
        int guard = 0;
        while (!cmd_ready && guard < 200) begin
            low++;
            guard++;
            step();
        end
        chk({tag, "_lat"}, 32'(low), 32'(VL + 1));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic do_mult(input string tag, input logic [4:0] dst);
        logic [31:0] r;
        r = dot_model();
        issue(OP_MUL, dst, 32'h0);
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        finish_mult(tag, 0);
        model[dst] = r;
        do_read({tag, "_rd"}, dst);
    endtask

    initial begin
        logic [31:0] r;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        opcode    = OP_NONE;
        addr      = '0;
        datain    = '0;
        last_read = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", dataout, 32'd0);
        chk("rst_dvalid", 32'(dataout_valid), 32'd0);

        // Random fill and random reads, back to back
        for (int i = 0; i < 32; i++) do_write(5'(i), $urandom);
        for (int k = 0; k < 8; k++) do_read("rnd_rd", 5'($urandom_range(0, 31)));
        step();
        chk("rd_valid_drop", 32'(dataout_valid), 32'd0);
        chk("rd_hold", dataout, last_read);

        // WRITE then READ on consecutive edges
        do_write(5'd5, 32'hDEADBEEF);
        do_read("wr_rd5", 5'd5);
        chk("wr_rd5_abs", dataout, 32'hDEADBEEF);
        step();
        chk("wr_rd5_pulse", 32'(dataout_valid), 32'd0);
        chk("wr_rd5_hold", dataout, 32'hDEADBEEF);

        // Directed dot product: sum (i+1)*2 = 72
        for (int i = 0; i < int'(VL); i++) begin
            do_write(5'(i), 32'(i + 1));
            do_write(5'(16 + i), 32'd2);
        end
        do_mult("mul72", 5'd31);
        chk("mul72_abs", dataout, 32'h48);

        // Randomized dot products, including destinations inside the operand range
        for (int k = 0; k < 4; k++) begin
            logic [4:0] d;
            for (int i = 0; i < 32; i++) do_write(5'(i), $urandom);
            d = (k == 0) ? 5'd3 : (k == 1) ? 5'd18 : 5'($urandom_range(0, 31));
            do_mult("mul_rnd", d);
        end

        // Wrap and overlap: 0xFFFFFFFF^2 truncates to 1, written over reg0
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'h0);
        do_write(5'd0, 32'hFFFFFFFF);
        do_write(5'd16, 32'hFFFFFFFF);
        do_mult("mul_wrap", 5'd0);
        chk("mul_wrap_abs", dataout, 32'h1);

        // Commands while busy are dropped
        do_write(5'd3, 32'h1234);
        r = dot_model();
        issue(OP_MUL, 5'd30, 32'h0);
        cmd_valid = 1'b1;
        opcode    = OP_WRITE;
        addr      = 5'd3;
        datain    = 32'd7;
        step();
        step();
        cmd_valid = 1'b0;
        opcode    = OP_NONE;
        finish_mult("mul_blk", 2);
        model[30] = r;
        do_read("blk_rd3", 5'd3);
        do_read("blk_rd30", 5'd30);

        // NONE opcode with cmd_valid produces nothing
        cmd_valid = 1'b1;
        opcode    = OP_NONE;
        addr      = 5'd5;
        step();
        cmd_valid = 1'b0;
        chk("none_dvalid", 32'(dataout_valid), 32'd0);
        chk("none_ready", 32'(cmd_ready), 32'd1);
        chk("none_busy", 32'(busy), 32'd0);
        chk("none_hold", dataout, last_read);

        // Reset during MAC aborts the MULTIPLY and clears everything
        for (int i = 0; i < 32; i++) do_write(5'(i), $urandom | 32'h1);
        issue(OP_MUL, 5'd9, 32'h0);
        step();
        step();
        step();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dout", dataout, 32'd0);
        for (int c = 0; c < 12; c++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        step();
        chk("abort_ready_post", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 32; i++) do_read("post_rst_rd", 5'(i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
